// File: rtl/bcd_timer4.sv
// Four-digit BCD up/down timer feeding the seven-segment decoders.
// Keys and switches give start/stop/clear/load; an internal prescaler paces the steps.
module bcd_timer4 #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    input  logic        up_down_i,
    output logic [3:0]  digit3_o,
    output logic [3:0]  digit2_o,
    output logic [3:0]  digit1_o,
    output logic [3:0]  digit0_o,
    output logic        running_o,
    output logic        done_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [15:0]   digits_q;
    logic [PW-1:0] presc_q;
    logic          running_q;
    logic          done_q;

    logic [4:0]    carry;
    logic [4:0]    borrow;
    logic [15:0]   inc_val;
    logic [15:0]   dec_val;
    logic [15:0]   load_clamped;
    logic [15:0]   step_d;
    logic          at_term;
    logic          step_term;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Ripple increment/decrement per digit; carry[4] means all nines, borrow[4] all zeros.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] dig;
        logic [3:0] lv;
        assign dig = digits_q[gi*4 +: 4];
        assign lv  = load_value_i[gi*4 +: 4];

        assign inc_val[gi*4 +: 4] = !carry[gi]     ? dig :
                                    (dig >= 4'd9)  ? 4'd0 : dig + 4'd1;
        assign dec_val[gi*4 +: 4] = !borrow[gi]    ? dig :
                                    (dig == 4'd0)  ? 4'd9 : dig - 4'd1;
        assign carry[gi+1]  = carry[gi]  & (dig == 4'd9);
        assign borrow[gi+1] = borrow[gi] & (dig == 4'd0);

        assign load_clamped[gi*4 +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end

    assign step_d    = up_down_i ? inc_val : dec_val;
    assign at_term   = up_down_i ? carry[4] : borrow[4];
    assign step_term = up_down_i ? (inc_val == 16'h9999) : (dec_val == 16'h0000);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            digits_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear_i) begin
                state_q   <= ST_IDLE;
                digits_q  <= '0;
                presc_q   <= '0;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (stop_i) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            // A direction flip can leave us already at the new terminal: stop, never wrap.
                            if (at_term) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                digits_q <= step_d;
                                if (step_term) begin
                                    state_q   <= ST_DONE;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    default: begin
                        if (load_i) begin
                            state_q  <= ST_IDLE;
                            digits_q <= load_clamped;
                            presc_q  <= '0;
                        end else if (start_i && state_q != ST_DONE) begin
                            if (at_term) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                                if (state_q == ST_IDLE) begin
                                    presc_q <= '0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign digit3_o  = digits_q[15:12];
    assign digit2_o  = digits_q[11:8];
    assign digit1_o  = digits_q[7:4];
    assign digit0_o  = digits_q[3:0];
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_timer4.sv
// Scoreboard bench for bcd_timer4: stimulus queues expected output changes with
// their cycle stamps; the monitor pops one entry whenever the outputs change.
module tb_bcd_timer4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        up_down;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic        running;
    logic        done;

    bcd_timer4 #(.TICK_DIV(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .clear_i      (clear),
        .load_i       (load),
        .load_value_i (load_value),
        .up_down_i    (up_down),
        .digit3_o     (digit3),
        .digit2_o     (digit2),
        .digit1_o     (digit1),
        .digit0_o     (digit0),
        .running_o    (running),
        .done_o       (done)
    );

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic        run;
        logic        dn;
    } ev_t;

    ev_t exp_q[$];

    int   cyc       = 0;
    int   snap_cyc  = -1;
    int   n_total   = 0;
    int   n_bad     = 0;
    int   t         = 0;
    bit   mon_en    = 1'b0;
    bit   end_req   = 1'b0;
    bit   end_ack   = 1'b0;
    logic [17:0] obs;
    logic [17:0] prev_obs = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {digit3, digit2, digit1, digit0, running, done};

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic r, input logic dn);
        ev_t e;
        e.cyc = c;
        e.dig = d;
        e.run = r;
        e.dn  = dn;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per observed output change (or requested snapshot).
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (obs != prev_obs || cyc == snap_cyc)) begin
            n_total = n_total + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_change cyc=%0d got digits=%h running=%b done=%b, required no change",
                         cyc, obs[17:2], obs[1], obs[0]);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.dig != obs[17:2] || e.run != obs[1] || e.dn != obs[0]) begin
                    n_bad = n_bad + 1;
                    $display("FAIL output_event got cyc=%0d digits=%h running=%b done=%b, required cyc=%0d digits=%h running=%b done=%b",
                             cyc, obs[17:2], obs[1], obs[0], e.cyc, e.dig, e.run, e.dn);
                end else begin
                    $display("ok cyc=%0d digits=%h running=%b done=%b", cyc, obs[17:2], obs[1], obs[0]);
                end
            end
        end
        if (end_req && !end_ack) begin
            n_total = n_total + 1;
            if (exp_q.size() != 0) begin
                n_bad = n_bad + 1;
                $display("FAIL missing_events got %0d pending, required 0 (next cyc=%0d digits=%h)",
                         exp_q.size(), exp_q[0].cyc, exp_q[0].dig);
            end
            end_ack = 1'b1;
        end
        prev_obs = obs;
    end

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
        load = 1'b0; load_value = 16'h0000; up_down = 1'b1;

        // Reset with start held high, then start accepted after release
        wait_cyc(3);
        t = cyc;
        push(t, 16'h0000, 1'b0, 1'b0);
        snap_cyc = t;
        mon_en = 1'b1;
        rst = 1'b0;
        push(t + 1, 16'h0000, 1'b1, 1'b0);
        push(t + 5, 16'h0001, 1'b1, 1'b0);
        wait_cyc(5);
        start = 1'b0; clear = 1'b1;
        push(t + 6, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0;

        // Carry across three digits
        t = cyc;
        load = 1'b1; load_value = 16'h0998; up_down = 1'b1;
        push(t + 1, 16'h0998, 1'b0, 1'b0);
        wait_cyc(1);
        load = 1'b0; start = 1'b1;
        push(t + 2, 16'h0998, 1'b1, 1'b0);
        push(t + 6, 16'h0999, 1'b1, 1'b0);
        push(t + 10, 16'h1000, 1'b1, 1'b0);
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(8);
        clear = 1'b1;
        push(t + 11, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0;

        // Count down to terminal, single done pulse, then quiet for 20 cycles
        t = cyc;
        load = 1'b1; load_value = 16'h0002; up_down = 1'b0;
        push(t + 1, 16'h0002, 1'b0, 1'b0);
        wait_cyc(1);
        load = 1'b0; start = 1'b1;
        push(t + 2, 16'h0002, 1'b1, 1'b0);
        push(t + 6, 16'h0001, 1'b1, 1'b0);
        push(t + 10, 16'h0000, 1'b0, 1'b1);
        push(t + 11, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(29);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;

        // Pause holds the prescaler; resume steps two cycles later
        t = cyc;
        load = 1'b1; load_value = 16'h0005; up_down = 1'b1;
        push(t + 1, 16'h0005, 1'b0, 1'b0);
        wait_cyc(1);
        load = 1'b0; start = 1'b1;
        push(t + 2, 16'h0005, 1'b1, 1'b0);
        wait_cyc(1);
        start = 1'b0;
        push(t + 6, 16'h0006, 1'b1, 1'b0);
        wait_cyc(6);
        stop = 1'b1;
        push(t + 9, 16'h0006, 1'b0, 1'b0);
        wait_cyc(1);
        stop = 1'b0;
        wait_cyc(10);
        start = 1'b1;
        push(t + 20, 16'h0006, 1'b1, 1'b0);
        push(t + 22, 16'h0007, 1'b1, 1'b0);
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(2);
        clear = 1'b1;
        push(t + 23, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0;

        // Clamped load, load ignored in RUN, clear+stop together
        t = cyc;
        load = 1'b1; load_value = 16'hFA3C; up_down = 1'b0;
        push(t + 1, 16'h9939, 1'b0, 1'b0);
        wait_cyc(1);
        load = 1'b0; start = 1'b1;
        push(t + 2, 16'h9939, 1'b1, 1'b0);
        wait_cyc(1);
        start = 1'b0; load = 1'b1; load_value = 16'h1234;
        push(t + 6, 16'h9938, 1'b1, 1'b0);
        wait_cyc(4);
        load = 1'b0; clear = 1'b1; stop = 1'b1;
        push(t + 7, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0; stop = 1'b0;

        // Start at terminal goes straight to DONE; start ignored until clear
        t = cyc;
        load = 1'b1; load_value = 16'h9999; up_down = 1'b1;
        push(t + 1, 16'h9999, 1'b0, 1'b0);
        wait_cyc(1);
        load = 1'b0; start = 1'b1;
        push(t + 2, 16'h9999, 1'b0, 1'b1);
        push(t + 3, 16'h9999, 1'b0, 1'b0);
        wait_cyc(1);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        wait_cyc(9);
        clear = 1'b1; start = 1'b0;
        push(t + 13, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0; start = 1'b1;
        push(t + 14, 16'h0000, 1'b1, 1'b0);
        wait_cyc(1);
        start = 1'b0; clear = 1'b1;
        push(t + 15, 16'h0000, 1'b0, 1'b0);
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(3);

        end_req = 1'b1;
        wait_cyc(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
